mode_select_ctrl: RTL and testbench

Parametrised play-mode controller for the music player. It debounces raw front-panel keys and turns them into single press events. It then maintains the current play mode (song/track index) over NUM_MODES modes, supporting direct-select with toggle-home, next/prev with wrap-around, and optional auto-advance on song end. It sits between the board key inputs and the tone/score sequencer, which consumes `mode` and `mode_changed`.

---
 rtl/music_pkg.sv | 19 +
 rtl/key_debounce.sv | 66 ++++++
 rtl/mode_select_ctrl.sv | 151 +++++++++++++++
 tb/tb_mode_select_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music player control blocks: the play-mode FSM
// state encoding, the mode-index width helper and the board debounce default.
package music_pkg;

    // Play-mode controller states: accept one key event, then wait for release.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_REL = 1'b1
    } mode_state_e;

    // 20000 cycles at the 50 MHz board clock is a 0.4 ms settle window.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 20000;

    // Width of a mode index; a single-mode-bit minimum keeps ports legal.
    function automatic int mode_width(input int num_modes);
        return (num_modes <= 2) ? 1 : $clog2(num_modes);
    endfunction

endpackage : music_pkg

// File: rtl/key_debounce.sv
// Per-key conditioning: 2-flop synchroniser, stability counter and debounced
// level, plus a one-cycle pulse in the cycle the level rises.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_lvl,
    output logic key_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             rise_q, rise_d;

    // Bring the asynchronous key into the clk domain.
    // NOTE: state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= key_raw;
            sync_q <= meta_q;
        end
    end

    // Count consecutive mismatch cycles; flip the level on the last one.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d  = '0;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        if (sync_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d  = sync_q;
                rise_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
        end
    end

    assign key_lvl  = lvl_q;
    assign key_rise = rise_q;

endmodule : key_debounce

// File: rtl/mode_select_ctrl.sv
// Play-mode controller: debounces the direct-select, next and previous keys
// and maintains the current mode index with toggle-home and wrap-around.
// Build option: define MODE_SEL_AUTO_ADV_EN to let song_done advance the mode
// in IDLE; without it song_done is ignored.
module mode_select_ctrl
    import music_pkg::*;
#(
    parameter int NUM_MODES       = 3,
    parameter int HOME_MODE       = 0,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int MODE_W          = mode_width(NUM_MODES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_MODES-1:0] switch,
    input  logic                 key_next,
    input  logic                 key_prev,
    input  logic                 song_done,
    output logic [MODE_W-1:0]    mode,
    output logic [NUM_MODES-1:0] mode_onehot,
    output logic                 mode_changed
);

    localparam int NUM_KEYS = NUM_MODES + 2;
    localparam int KEY_NEXT = NUM_MODES;
    localparam int KEY_PREV = NUM_MODES + 1;

    localparam logic [MODE_W-1:0]    MODE_HOME   = MODE_W'(HOME_MODE);
    localparam logic [MODE_W-1:0]    MODE_LAST   = MODE_W'(NUM_MODES - 1);
    localparam logic [NUM_MODES-1:0] ONEHOT_HOME = NUM_MODES'(1) << HOME_MODE;

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_lvl;
    logic [NUM_KEYS-1:0] key_rise;

    mode_state_e state_q, state_d;

    logic [MODE_W-1:0]    mode_q, mode_d;
    logic [NUM_MODES-1:0] onehot_q, onehot_d;
    logic                 changed_q, changed_d;

    logic              sw_hit;
    logic [MODE_W-1:0] sw_idx;
    logic              any_key_lvl;
    logic              key_event;
    logic              next_rise;
    logic              prev_rise;

    assign key_raw = {key_prev, key_next, switch};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_raw (key_raw[k]),
            .key_lvl (key_lvl[k]),
            .key_rise(key_rise[k])
        );
    end

    assign any_key_lvl = |key_lvl;
    assign key_event   = |key_rise;
    assign next_rise   = key_rise[KEY_NEXT];
    assign prev_rise   = key_rise[KEY_PREV];

    // Explicit wrap compares: NUM_MODES need not be a power of two.
    function automatic logic [MODE_W-1:0] step_next(input logic [MODE_W-1:0] m);
        return (m == MODE_LAST) ? '0 : m + MODE_W'(1);
    endfunction

    function automatic logic [MODE_W-1:0] step_prev(input logic [MODE_W-1:0] m);
        return (m == '0) ? MODE_LAST : m - MODE_W'(1);
    endfunction

    // Lowest-index direct-select press wins: scan downwards, last hit sticks.
    always_comb begin
        sw_hit = 1'b0;
        sw_idx = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (key_rise[i]) begin
                sw_hit = 1'b1;
                sw_idx = MODE_W'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any key event locks out further keys until all are released.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (key_event)    state_d = WAIT_REL;
            WAIT_REL: if (!any_key_lvl) state_d = IDLE;
        endcase
    end

    // Mode update: direct-select, then next/prev (cancelling), then auto-advance.
    always_comb begin
        mode_d = mode_q;
        if (state_q == IDLE) begin
            if (sw_hit) begin
                mode_d = (sw_idx == mode_q) ? MODE_HOME : sw_idx;
            end else if (next_rise && !prev_rise) begin
                mode_d = step_next(mode_q);
            end else if (prev_rise && !next_rise) begin
                mode_d = step_prev(mode_q);
            end
`ifdef MODE_SEL_AUTO_ADV_EN
            else if (!key_event && song_done) begin
                mode_d = step_next(mode_q);
            end
`endif
        end
        changed_d = (mode_d != mode_q);
        onehot_d  = NUM_MODES'(1) << mode_d;
    end

`ifndef MODE_SEL_AUTO_ADV_EN
    // Without auto-advance the end-of-score pulse has no consumer.
    logic unused_song_done;
    assign unused_song_done = song_done;
`endif

    // Registered outputs; the one-hot copy is stored rather than decoded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_HOME;
            onehot_q  <= ONEHOT_HOME;
            changed_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            onehot_q  <= onehot_d;
            changed_q <= changed_d;
        end
    end

    assign mode         = mode_q;
    assign mode_onehot  = onehot_q;
    assign mode_changed = changed_q;

endmodule : mode_select_ctrl

// File: tb/tb_mode_select_ctrl.sv
// Directed bench for mode_select_ctrl with NUM_MODES=3, DEBOUNCE_CYCLES=4,
// HOME_MODE=0: a vector table for single key presses plus hand-written
// sequences for latency, hold, glitch rejection, song_done and reset.
module tb_mode_select_ctrl;

    localparam int NUM_MODES = 3;
    localparam int DEB       = 4;
    localparam int SETTLE    = 12;  // comfortably above DEB+3 edges

    logic       clk;
    logic       rst_n;
    logic [2:0] switch;
    logic       key_next;
    logic       key_prev;
    logic       song_done;
    logic [1:0] mode;
    logic [2:0] mode_onehot;
    logic       mode_changed;

    int checks;
    int failures;
    int pulse_cnt;

    typedef struct {
        logic [2:0] sw;
        logic       nx;
        logic       pv;
        int         exp_mode;
        int         exp_pulses;
        string      name;
    } vec_t;

    vec_t vecs[13];

    mode_select_ctrl #(
        .NUM_MODES      (NUM_MODES),
        .HOME_MODE      (0),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .switch      (switch),
        .key_next    (key_next),
        .key_prev    (key_prev),
        .song_done   (song_done),
        .mode        (mode),
        .mode_onehot (mode_onehot),
        .mode_changed(mode_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count mode_changed pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n && mode_changed) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Hold a key combination long enough to register, then release and settle.
    task automatic apply_keys(input logic [2:0] sw, input logic nx, input logic pv);
        switch   = sw;
        key_next = nx;
        key_prev = pv;
        repeat (SETTLE) @(posedge clk);
        #1;
        switch   = '0;
        key_next = 1'b0;
        key_prev = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int start;
        int lat;
        int lat_changed;

        checks    = 0;
        failures  = 0;
        pulse_cnt = 0;

        vecs[0]  = '{3'b100, 1'b0, 1'b0, 0, 1, "sw2_toggle_home"};
        vecs[1]  = '{3'b001, 1'b0, 1'b0, 0, 0, "sw0_at_home"};
        vecs[2]  = '{3'b100, 1'b0, 1'b0, 2, 1, "sw2_select"};
        vecs[3]  = '{3'b000, 1'b1, 1'b0, 0, 1, "next_wrap"};
        vecs[4]  = '{3'b000, 1'b0, 1'b1, 2, 1, "prev_wrap"};
        vecs[5]  = '{3'b000, 1'b0, 1'b1, 1, 1, "prev_step"};
        vecs[6]  = '{3'b000, 1'b1, 1'b0, 2, 1, "next_step"};
        vecs[7]  = '{3'b110, 1'b0, 1'b0, 1, 1, "sw_lowest_wins"};
        vecs[8]  = '{3'b000, 1'b1, 1'b1, 1, 0, "next_prev_cancel"};
        vecs[9]  = '{3'b001, 1'b1, 1'b0, 0, 1, "sw_over_next"};
        vecs[10] = '{3'b010, 1'b0, 1'b0, 1, 1, "sw1_select"};
        vecs[11] = '{3'b010, 1'b0, 1'b0, 0, 1, "sw1_toggle_home"};
        vecs[12] = '{3'b010, 1'b0, 1'b0, 1, 1, "sw1_reselect"};

        rst_n     = 1'b0;
        switch    = '0;
        key_next  = 1'b0;
        key_prev  = 1'b0;
        song_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mode", int'(mode), 0);
        check("reset_onehot", int'(mode_onehot), 1);
        check("reset_changed", int'(mode_changed), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Key latency: switch[2] raised before edge 1 must land on edge DEB+3.
        start       = pulse_cnt;
        lat         = 0;
        lat_changed = 0;
        switch      = 3'b100;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (mode == 2'd2) begin
                lat         = n;
                lat_changed = int'(mode_changed);
                break;
            end
        end
        check("press_latency_edges", lat, DEB + 3);
        check("press_latency_changed", lat_changed, 1);
        check("press_onehot", int'(mode_onehot), 4);
        repeat (50) @(posedge clk);
        #1;
        check("hold_mode", int'(mode), 2);
        check("hold_pulses", pulse_cnt - start, 1);
        switch = '0;
        repeat (SETTLE) @(posedge clk);
        #1;

        // Single-event table, starting from mode 2.
        for (int v = 0; v < $size(vecs); v++) begin
            start = pulse_cnt;
            apply_keys(vecs[v].sw, vecs[v].nx, vecs[v].pv);
            check({vecs[v].name, "_mode"}, int'(mode), vecs[v].exp_mode);
            check({vecs[v].name, "_onehot"}, int'(mode_onehot), 1 << vecs[v].exp_mode);
            check({vecs[v].name, "_pulses"}, pulse_cnt - start, vecs[v].exp_pulses);
        end

        // Glitching switch[1]: 3 high / 1 low never reaches DEB stable cycles.
        start = pulse_cnt;
        for (int r = 0; r < 10; r++) begin
            switch = 3'b010;
            repeat (3) @(posedge clk);
            #1;
            switch = '0;
            @(posedge clk);
            #1;
        end
        repeat (SETTLE) @(posedge clk);
        #1;
        check("glitch_mode", int'(mode), 1);
        check("glitch_pulses", pulse_cnt - start, 0);

        // song_done pulse in IDLE at mode 1.
        start     = pulse_cnt;
        song_done = 1'b1;
        @(posedge clk);
        #1;
        song_done = 1'b0;
`ifdef MODE_SEL_AUTO_ADV_EN
        check("song_done_mode", int'(mode), 2);
        check("song_done_onehot", int'(mode_onehot), 4);
        repeat (2) @(posedge clk);
        #1;
        check("song_done_pulses", pulse_cnt - start, 1);
`else
        check("song_done_mode", int'(mode), 1);
        check("song_done_onehot", int'(mode_onehot), 2);
        repeat (2) @(posedge clk);
        #1;
        check("song_done_pulses", pulse_cnt - start, 0);
`endif

        // Reset mid-debounce, with the key held through reset release.
        switch = 3'b100;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_mode", int'(mode), 0);
        check("midreset_onehot", int'(mode_onehot), 1);
        check("midreset_changed", int'(mode_changed), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = pulse_cnt;
        repeat (SETTLE) @(posedge clk);
        #1;
        check("held_through_reset_mode", int'(mode), 2);
        check("held_through_reset_pulses", pulse_cnt - start, 1);
        switch = '0;
        repeat (SETTLE) @(posedge clk);
        #1;
        check("final_mode", int'(mode), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mode_select_ctrl
